// File: rtl/pipe_injector.sv
// pipe_injector: clocked valid/ready FIFO that issues one 4-phase bundled-data token per word.
// Optional ack watchdog is compiled in with `define PIPE_INJECTOR_TIMEOUT_EN.
module pipe_injector #(
   parameter int DATA_W      = 3,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int SETUP_CYC   = 1,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              req_out,
   output logic [DATA_W-1:0] data_out,
   input  logic              ack_in,
   output logic              busy,
   output logic              err_timeout
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int SET_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_t;

   logic [DATA_W-1:0]      r_mem [DEPTH];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [CNT_W-1:0]       r_count;
   logic                   r_run;
   logic [SYNC_STAGES-1:0] r_sync;
   state_t                 r_state;
   logic [SET_W-1:0]       r_setup_cnt;
   logic                   w_ack_s;
   logic                   w_push;
   logic                   w_pop;

   assign w_ack_s  = r_sync[SYNC_STAGES-1];
   // r_run keeps wr_ready low until the first clock edge after reset release
   assign wr_ready = r_run && (r_count != CNT_W'(DEPTH));
   assign w_push   = wr_valid && wr_ready;
   assign w_pop    = (r_state == REQ_HI) && w_ack_s;
   assign busy     = (r_count != '0) || (r_state != IDLE);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run    <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_sync   <= '0;
      end else begin
         r_run  <= 1'b1;
         r_sync <= {r_sync[SYNC_STAGES-2:0], ack_in};
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // The head word stays in the FIFO until the stage acknowledges it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_setup_cnt <= '0;
         req_out     <= 1'b0;
         data_out    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if ((r_count != '0) && !w_ack_s) begin
                  data_out    <= r_mem[r_rd_ptr];
                  r_setup_cnt <= '0;
                  r_state     <= SETUP;
               end
            end
            SETUP: begin
               if (r_setup_cnt == SET_W'(SETUP_CYC - 1)) begin
                  req_out <= 1'b1;
                  r_state <= REQ_HI;
               end else begin
                  r_setup_cnt <= r_setup_cnt + SET_W'(1);
               end
            end
            REQ_HI: begin
               if (w_ack_s) begin
                  req_out <= 1'b0;
                  r_state <= REQ_LO;
               end
            end
            REQ_LO: begin
               if (!w_ack_s) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               req_out <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef PIPE_INJECTOR_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_err;
   logic            w_wait;

   // Waiting means sitting in a handshake state with no transition this cycle
   assign w_wait = ((r_state == REQ_HI) && !w_ack_s) || ((r_state == REQ_LO) && w_ack_s);
   assign err_timeout = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
         r_err    <= 1'b0;
      end else if (w_wait) begin
         if (r_to_cnt != TO_W'(TIMEOUT_CYC)) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end
         if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            r_err <= 1'b1;
         end
      end else begin
         r_to_cnt <= '0;
      end
   end
`else
   // Always false for any legal TIMEOUT_CYC; keeps the parameter referenced
   assign err_timeout = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_pipe_injector.sv
// Directed self-checking bench for pipe_injector with a behavioural first-stage model.
`timescale 1ns/1ps
module tb_pipe_injector;
   localparam int DW = 3;
`ifdef PIPE_INJECTOR_TIMEOUT_EN
   localparam int TO = 20;
`else
   localparam int TO = 255;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          wr_valid = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ready;
   logic          req_out;
   logic [DW-1:0] data_out;
   logic          ack_in;
   logic          busy;
   logic          err_timeout;

   int checks = 0;
   int failures = 0;

   logic          stage_en = 1'b0;
   logic          manual_ack = 1'b0;
   logic          m_ack = 1'b0;
   int            m_cnt = 0;
   int            ack_delay = 2;
   logic [DW-1:0] tok_q[$];

   assign ack_in = stage_en ? m_ack : manual_ack;

   pipe_injector #(
      .DATA_W(DW), .DEPTH(4), .SYNC_STAGES(2), .SETUP_CYC(1), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data), .req_out(req_out), .data_out(data_out), .ack_in(ack_in),
      .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // First pipeline stage: acks a held request after ack_delay+1 cycles, logs the token
   always @(negedge clk) begin
      if (!rst_n) begin
         m_ack = 1'b0;
         m_cnt = 0;
      end else if (stage_en) begin
         if (req_out && !m_ack) begin
            if (m_cnt >= ack_delay) begin
               m_ack = 1'b1;
               m_cnt = 0;
               tok_q.push_back(data_out);
            end else begin
               m_cnt++;
            end
         end else if (!req_out && m_ack) begin
            m_ack = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; returns at the negedge following the accepting edge
   task automatic push(input logic [DW-1:0] d);
      int n = 0;
      wr_valid = 1'b1;
      wr_data  = d;
      while (wr_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("push_ready", wr_ready, 1);
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic wait_req(input logic lvl, input string tag);
      int n = 0;
      while (req_out !== lvl && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(tag, req_out, lvl);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy !== 1'b0 || req_out !== 1'b0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, busy, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      wr_valid = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic req_seen;

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req", req_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_timeout, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rel_wr_ready_before_edge", wr_ready, 0);
      @(negedge clk);
      chk("rel_wr_ready_first_edge", wr_ready, 1);

      // Single word 3'b101
      stage_en  = 1'b1;
      ack_delay = 2;
      wr_valid  = 1'b1;
      wr_data   = 3'b101;
      @(negedge clk);
      wr_valid = 1'b0;
      chk("single_T_req", req_out, 0);
      chk("single_T_data", data_out, 0);
      @(negedge clk);
      chk("single_T1_data", data_out, 3'b101);
      chk("single_T1_req", req_out, 0);
      @(negedge clk);
      chk("single_T2_req", req_out, 1);
      chk("single_T2_busy", busy, 1);
      wait_idle("single_idle");
      chk("single_tokens", tok_q.size(), 1);
      chk("single_tok0", tok_q[0], 3'b101);
      chk("single_data_held", data_out, 3'b101);
      chk("single_wr_ready", wr_ready, 1);

      // Fill and backpressure
      tok_q.delete();
      stage_en   = 1'b0;
      manual_ack = 1'b0;
      push(3'd1);
      push(3'd2);
      push(3'd3);
      chk("fill_ready_3", wr_ready, 1);
      push(3'd4);
      chk("fill_full_ready", wr_ready, 0);
      wr_valid = 1'b1;
      wr_data  = 3'd5;
      repeat (3) @(negedge clk);
      chk("fill_held_ready", wr_ready, 0);
      chk("fill_head_req", req_out, 1);
      chk("fill_head_data", data_out, 3'd1);
      stage_en = 1'b1;
      push(3'd5);
      chk("fill_5_after_token", tok_q.size() >= 1, 1);
      wait_idle("fill_idle");
      chk("fill_tokens", tok_q.size(), 5);
      for (int i = 0; i < 5; i++) chk($sformatf("fill_tok%0d", i), tok_q[i], i + 1);

      // Ordering and pointer wrap with a fast stage
      tok_q.delete();
      ack_delay = 0;
      for (int i = 0; i < 10; i++) push(DW'(i % 8));
      wait_idle("wrap_idle");
      chk("wrap_tokens", tok_q.size(), 10);
      for (int i = 0; i < 10; i++) chk($sformatf("wrap_tok%0d", i), tok_q[i], i % 8);

      // Stale ack held through reset release
      stage_en   = 1'b0;
      manual_ack = 1'b1;
      do_reset();
      push(3'b010);
      req_seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (req_out !== 1'b0) req_seen = 1'b1;
      end
      chk("stale_no_req", req_seen, 0);
      chk("stale_busy", busy, 1);
      manual_ack = 1'b0;
      wait_req(1'b1, "stale_req_up");
      chk("stale_data", data_out, 3'b010);
      manual_ack = 1'b1;
      wait_req(1'b0, "stale_req_down");
      manual_ack = 1'b0;
      wait_idle("stale_idle");

      // Reset in the middle of a handshake
      push(3'd6);
      push(3'd7);
      wait_req(1'b1, "mid_req_up");
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_req", req_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_wr_ready", wr_ready, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tok_q.delete();
      stage_en = 1'b1;
      repeat (30) @(negedge clk);
      chk("mid_no_replay", tok_q.size(), 0);
      chk("mid_req_after", req_out, 0);
      chk("mid_busy_after", busy, 0);
      chk("mid_wr_ready_after", wr_ready, 1);

`ifdef PIPE_INJECTOR_TIMEOUT_EN
      // Watchdog: stage never acknowledges
      stage_en   = 1'b0;
      manual_ack = 1'b0;
      push(3'd3);
      wait_req(1'b1, "to_req_up");
      repeat (19) @(negedge clk);
      chk("to_err_before", err_timeout, 0);
      @(negedge clk);
      chk("to_err_set", err_timeout, 1);
      repeat (10) @(negedge clk);
      chk("to_err_sticky", err_timeout, 1);
      chk("to_req_still_high", req_out, 1);
      do_reset();
      chk("to_err_cleared", err_timeout, 0);
`else
      chk("err_tied_low", err_timeout, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
